// File: rtl/mdma_pkg.sv
// mdma_pkg: shared constants and FSM state type for the DMA read burst scheduler.
//   AXI_MAX_BURST - longest AXI3 INCR burst in beats
//   BEAT_BYTES    - bytes per 64-bit data beat
//   PAGE_BEATS    - beats in one 4 KB page (bursts must not cross a page)
package mdma_pkg;

    localparam int AXI_MAX_BURST = 16;
    localparam int BEAT_BYTES    = 8;
    localparam int PAGE_BEATS    = 512;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT_DROP,
        WAIT_FREE,
        FINISH
    } sched_state_e;

endpackage

// File: rtl/mdma_burst_len_calc.sv
// mdma_burst_len_calc: combinational length of the next burst,
// min(AXI_MAX_BURST, remaining beats, beats left in the current 4 KB page).
// Ports:
//   remaining_i [LEN_W-1:0]  beats still to request (never 0 when used)
//   page_off_i  [8:0]        beat offset of the burst start inside its page
//   len_o       [4:0]        resulting burst length, 1..16
module mdma_burst_len_calc
    import mdma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [LEN_W-1:0] remaining_i,
    input  logic [8:0]       page_off_i,
    output logic [4:0]       len_o
);

    // One bit wider than the beat count so that 512 - offset (up to 512)
    // and the full remaining count compare without overflow.
    logic [LEN_W:0] rem_w;
    logic [LEN_W:0] page_left_w;
    logic [LEN_W:0] min_w;

    always_comb begin
        rem_w       = {1'b0, remaining_i};
        page_left_w = (LEN_W+1)'(PAGE_BEATS) - (LEN_W+1)'(page_off_i);
        min_w       = (LEN_W+1)'(AXI_MAX_BURST);
        if (rem_w < min_w) begin
            min_w = rem_w;
        end
        if (page_left_w < min_w) begin
            min_w = page_left_w;
        end
        len_o = 5'(min_w);
    end

endmodule

// File: rtl/mdma_read_sched.sv
// mdma_read_sched: splits one read request into page-safe AXI3 bursts and
// launches them one at a time on the read engine, gated on FIFO space.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_addr (bits [2:0] ignored),
//                           req_beats (0 allowed)
//   busy, done              transfer in progress / 1-cycle completion pulse
//   rd_valid                1-cycle burst launch to the engine
//   rd_head_addr/burst_len  burst descriptor, stable outside CALC
//   rd_free                 engine idle indication
//   fifo_count              read-data FIFO occupancy
// Optional build macro MDMA_SCHED_PERF_EN adds stall_cycles[31:0] and
// burst_count[15:0] saturating performance counters.
module mdma_read_sched
    import mdma_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int CNT_W      = 9,
    parameter int LEN_W      = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_beats,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    output logic [31:0]      rd_head_addr,
    output logic [4:0]       rd_burst_len,
    input  logic             rd_free,
`ifdef MDMA_SCHED_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [15:0]      burst_count,
`endif
    input  logic [CNT_W-1:0] fifo_count
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    sched_state_e     state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [31:0]      head_addr_q, head_addr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [4:0]       burst_len_q, burst_len_d;
    logic [4:0]       calc_len;
    logic             issue_ok;

    mdma_burst_len_calc #(.LEN_W(LEN_W)) u_len_calc (
        .remaining_i (remaining_q),
        .page_off_i  (cur_addr_q[11:3]),
        .len_o       (calc_len)
    );

    // Launch only when the whole burst is guaranteed to fit in the FIFO.
    assign issue_ok = rd_free &&
                      (({1'b0, fifo_count} + (CNT_W+1)'(burst_len_q)) <= DEPTH_C);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        head_addr_d = head_addr_q;
        remaining_d = remaining_q;
        burst_len_d = burst_len_q;
        req_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        rd_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    cur_addr_d  = req_addr & ~32'h7;
                    remaining_d = req_beats;
                    state_d     = (req_beats == '0) ? FINISH : CALC;
                end
            end
            CALC: begin
                burst_len_d = calc_len;
                head_addr_d = cur_addr_q;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (issue_ok) begin
                    rd_valid    = 1'b1;
                    // Address advance wraps modulo 2^32 by construction.
                    cur_addr_d  = cur_addr_q + {24'b0, burst_len_q, 3'b000};
                    remaining_d = remaining_q - LEN_W'(burst_len_q);
                    state_d     = WAIT_DROP;
                end
            end
            // The engine's free flag lags the launch, so it is not trusted here.
            WAIT_DROP: state_d = WAIT_FREE;
            WAIT_FREE: begin
                if (rd_free) begin
                    state_d = (remaining_q == '0) ? FINISH : CALC;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            head_addr_q <= '0;
            remaining_q <= '0;
            burst_len_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            head_addr_q <= head_addr_d;
            remaining_q <= remaining_d;
            burst_len_q <= burst_len_d;
        end
    end

    assign rd_head_addr = head_addr_q;
    assign rd_burst_len = burst_len_q;

`ifdef MDMA_SCHED_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] burst_count_q;

    always_ff @(posedge aclk) begin
        if (areset || (state_q == IDLE && req_valid)) begin
            stall_cycles_q <= '0;
            burst_count_q  <= '0;
        end else begin
            if (state_q == ISSUE && !issue_ok && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (rd_valid && burst_count_q != '1) begin
                burst_count_q <= burst_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign burst_count  = burst_count_q;
`endif

endmodule

// File: tb/tb_mdma_read_sched.sv
module tb_mdma_read_sched;

    localparam int FIFO_DEPTH = 256;
    localparam int CNT_W      = 9;
    localparam int LEN_W      = 16;

    logic             aclk = 1'b0;
    logic             areset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_beats;
    logic             busy;
    logic             done;
    logic             rd_valid;
    logic [31:0]      rd_head_addr;
    logic [4:0]       rd_burst_len;
    logic             rd_free;
    logic [CNT_W-1:0] fifo_count;
`ifdef MDMA_SCHED_PERF_EN
    logic [31:0]      stall_cycles;
    logic [15:0]      burst_count;
`endif

    always #5 aclk = ~aclk;

    mdma_read_sched #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_beats    (req_beats),
        .busy         (busy),
        .done         (done),
        .rd_valid     (rd_valid),
        .rd_head_addr (rd_head_addr),
        .rd_burst_len (rd_burst_len),
        .rd_free      (rd_free),
`ifdef MDMA_SCHED_PERF_EN
        .stall_cycles (stall_cycles),
        .burst_count  (burst_count),
`endif
        .fifo_count   (fifo_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    int     checks = 0;
    int     failures = 0;
    burst_t exp_q[$];
    burst_t mon_e;
    int     exp_done = 0;
    int     done_seen = 0;
    int     valid_seen = 0;

    // Read engine model: free drops after a launch, returns after a delay.
    logic   eng_free;
    int     eng_cnt;
    logic   hold_low = 1'b0;
    logic   rand_fifo = 1'b0;
    logic [CNT_W-1:0] fifo_fixed = '0;
    logic [CNT_W-1:0] fifo_rand = '0;

    assign rd_free    = eng_free;
    assign fifo_count = rand_fifo ? fifo_rand : fifo_fixed;

    always @(posedge aclk) begin
        if (areset) begin
            eng_free <= 1'b1;
            eng_cnt  <= 0;
        end else if (rd_valid) begin
            eng_free <= 1'b0;
            eng_cnt  <= rand_fifo ? int'($urandom_range(1, 5)) : 4;
        end else if (!eng_free) begin
            if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
            else if (!hold_low) eng_free <= 1'b1;
        end
        fifo_rand <= CNT_W'($urandom_range(0, 255));
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT launches a burst or finishes.
    always @(negedge aclk) begin
        if (areset === 1'b0) begin
            if (rd_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_burst actual=(0x%08h,%0d) required=none",
                             rd_head_addr, rd_burst_len);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("burst_addr", rd_head_addr, mon_e.addr);
                    check("burst_len", rd_burst_len, mon_e.len);
                end
                check("issue_rd_free", rd_free, 1);
                check("issue_fifo_fit",
                      (int'(fifo_count) + int'(rd_burst_len) <= FIFO_DEPTH) ? 1 : 0, 1);
                $display("burst addr=0x%08h len=%0d fifo=%0d", rd_head_addr, rd_burst_len, fifo_count);
            end
            if (done) begin
                done_seen++;
                if (exp_done == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    exp_done--;
                    check("done_after_all_bursts", exp_q.size(), 0);
                end
                $display("done pulse #%0d", done_seen);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference model: page-safe split with plain arithmetic.
    task automatic push_model(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, off, len;
        burst_t b;
        a   = addr & 32'hFFFF_FFF8;
        rem = beats;
        while (rem > 0) begin
            off = int'((a >> 3) % 512);
            len = 16;
            if (rem < len) len = rem;
            if (512 - off < len) len = 512 - off;
            b.addr = a;
            b.len  = len;
            exp_q.push_back(b);
            a   = a + 32'(len * 8);
            rem = rem - len;
        end
        exp_done++;
    endtask

    task automatic push_burst(input logic [31:0] addr, input int len);
        burst_t b;
        b.addr = addr;
        b.len  = len;
        exp_q.push_back(b);
    endtask

    task automatic start_req(input logic [31:0] addr, input int beats);
        int n = 0;
        while (!req_ready && n < 300) begin
            tick();
            n++;
        end
        check("req_ready_before_request", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_beats = LEN_W'(beats);
        tick();
        req_valid = 1'b0;
        $display("request addr=0x%08h beats=%0d", addr, beats);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n = 0;
        while (done_seen < target && n < budget) begin
            tick();
            n++;
        end
        check(name, done_seen, target);
    endtask

    initial begin
        int v0, d0, n;
        logic [31:0] r, a;
        int beats;

        areset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_beats = '0;
        tick();
        tick();
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_head_addr", rd_head_addr, 0);
        check("reset_burst_len", rd_burst_len, 0);
        areset = 1'b0;
        tick();

        // Aligned 40-beat transfer.
        v0 = valid_seen;
        push_burst(32'h1000, 16);
        push_burst(32'h1080, 16);
        push_burst(32'h1100, 8);
        exp_done++;
        start_req(32'h1000, 40);
        wait_done("t1_done", 1, 400);
        check("t1_burst_count", valid_seen - v0, 3);
        tick();

        // Transfer straddling the 0x2000 page boundary.
        v0 = valid_seen;
        push_burst(32'h1FC0, 8);
        push_burst(32'h2000, 12);
        exp_done++;
        start_req(32'h1FC0, 20);
        wait_done("t2_done", 2, 400);
        check("t2_burst_count", valid_seen - v0, 2);
        tick();

        // Zero-length request.
        v0 = valid_seen;
        exp_done++;
        start_req(32'h4000, 0);
        wait_done("t3_done_latency", 3, 3);
        check("t3_no_burst", valid_seen - v0, 0);
        tick();
        check("t3_req_ready_back", req_ready, 1);

        // FIFO-space stall: 245 + 16 > 256, then 240 + 16 == 256 is allowed.
        v0 = valid_seen;
        fifo_fixed = 9'd245;
        push_burst(32'h0, 16);
        exp_done++;
        start_req(32'h0, 16);
        for (int i = 0; i < 10; i++) tick();
        check("t4_stall_no_valid", valid_seen - v0, 0);
        check("t4_busy_while_stalled", busy, 1);
        fifo_fixed = 9'd240;
        tick();
        check("t4_issue_after_drop", valid_seen - v0, 1);
        wait_done("t4_done", 4, 100);
        fifo_fixed = '0;
        tick();

        // Engine held busy: no second launch, and no new request accepted.
        v0 = valid_seen;
        hold_low = 1'b1;
        push_model(32'h0000_8000, 32);
        start_req(32'h0000_8000, 32);
        n = 0;
        while (valid_seen == v0 && n < 50) begin
            tick();
            n++;
        end
        check("t5_first_launch", valid_seen - v0, 1);
        for (int i = 0; i < 20; i++) begin
            req_valid = (i >= 5 && i < 9);
            req_addr  = 32'h5000;
            req_beats = 16'd8;
            if (i >= 5 && i < 9) check("t5_req_ready_low", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        check("t5_no_second_launch", valid_seen - v0, 1);
        hold_low = 1'b0;
        wait_done("t5_done", 5, 200);
        tick();

        // Reset while waiting for the engine: drop transfer silently.
        v0 = valid_seen;
        push_model(32'h3000, 64);
        start_req(32'h3000, 64);
        n = 0;
        while (valid_seen == v0 && n < 50) begin
            tick();
            n++;
        end
        check("t6_first_launch", valid_seen - v0, 1);
        tick();
        tick();
        exp_q.delete();
        exp_done = 0;
        d0 = done_seen;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("t6_busy_after_reset", busy, 0);
        check("t6_ready_after_reset", req_ready, 1);
        check("t6_rd_valid_after_reset", rd_valid, 0);
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_done", done_seen - d0, 0);

        // Randomized transfers against the reference model.
        rand_fifo = 1'b1;
        for (int t = 0; t < 16; t++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: a = r;
                1: a = (r & 32'hFFFF_F000) | 32'h0000_0F00 | (32'($urandom_range(0, 31)) << 3);
                2: a = 32'hFFFF_FF00 | (32'($urandom_range(0, 31)) << 3);
                default: a = (r & 32'hFFFF_F000) | (32'($urandom_range(0, 7)));
            endcase
            a = a | 32'($urandom_range(0, 7));
            beats = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200));
            d0 = done_seen;
            push_model(a, beats);
            start_req(a, beats);
            wait_done("rand_done", d0 + 1, 6000);
            tick();
        end
        rand_fifo = 1'b0;

        check("final_bursts_drained", exp_q.size(), 0);
        check("final_done_drained", exp_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdma_read_sched.md
Name: mdma_read_sched

Overview:
- Burst scheduler in front of the DMA AXI read engine.
- Accepts one transfer request (start address, total 64-bit beats) and splits it into AXI3 bursts of 1..16 beats that never cross a 4 KB boundary.
- Issues one burst at a time on the engine's valid/head_addr/burst_len/free interface, gated on space in the downstream read-data FIFO.
- Pulses done once the last burst has fully returned.

Parameters:
- FIFO_DEPTH, 256: depth in 64-bit words of the downstream read-data FIFO.
- CNT_W, 9: width of fifo_count; must hold 0..FIFO_DEPTH.
- LEN_W, 16: width of the request beat count.

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous reset, active-high.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  scheduler can accept a request.
- req_addr  in  32  start byte address; bits [2:0] ignored (treated as 0).
- req_beats  in  LEN_W  total beats to read; 0 is legal.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- rd_valid  out  1  one-cycle burst launch pulse to the read engine.
- rd_head_addr  out  32  burst start address, 8-byte aligned.
- rd_burst_len  out  5  burst beat count, 1..16.
- rd_free  in  1  read engine idle; drops the cycle after rd_valid, rises after rlast.
- fifo_count  in  CNT_W  current occupancy of the read-data FIFO.

Behaviour:
- Reset values:
  - req_ready=1, busy=0, done=0, rd_valid=0, rd_head_addr=0, rd_burst_len=0.
  - State = IDLE; internal cur_addr and remaining = 0.
- States: IDLE, CALC, ISSUE, WAIT_DROP, WAIT_FREE, FINISH.
- IDLE:
  - req_ready=1.
  - On req_valid, latch cur_addr={req_addr[31:3],3'b000} and remaining=req_beats.
  - Then go to CALC, or to FINISH if req_beats==0.
  - req_ready=0 in every other state.
- CALC (1 cycle):
  - Compute len = min(16, remaining, 512 - cur_addr[11:3]) using LEN_W+1-bit arithmetic.
  - Register len into rd_burst_len and cur_addr into rd_head_addr.
- ISSUE:
  - Wait until rd_free==1 and fifo_count + rd_burst_len <= FIFO_DEPTH (compare at CNT_W+1 bits).
  - When both hold, assert rd_valid for exactly 1 cycle.
  - In the same edge: cur_addr += rd_burst_len*8 and remaining -= rd_burst_len. Go to WAIT_DROP.
- WAIT_DROP (1 cycle): unconditional. The engine's free is registered and is still high in this cycle, so it is ignored here.
- WAIT_FREE:
  - When rd_free==1: go to FINISH if remaining==0, else to CALC.
- FINISH: done=1 for one cycle, busy=0 next; back to IDLE.
- busy=1 in every state except IDLE.
- rd_head_addr and rd_burst_len hold their value outside CALC, so they are stable while the engine samples them.
- Minimum gap between successive rd_valid pulses: ISSUE → WAIT_DROP → WAIT_FREE (≥1 cycle) → CALC → ISSUE.
- Boundary cases:
  - Address wrap past 0xFFFF_FFF8: wraps modulo 2^32, no error.
  - A burst ending exactly on a 4 KB boundary is legal; the next burst starts at the boundary.
  - fifo_count == FIFO_DEPTH - len: issue allowed. One more word: stall in ISSUE.
  - req_valid outside IDLE: ignored, since req_ready=0.
  - areset asserted mid-transfer: return to IDLE next edge with reset values and no done pulse. The read engine shares the reset.

Optional Feature:
- Macro: MDMA_SCHED_PERF_EN.
- When defined, adds two outputs:
  - stall_cycles [31:0]: counts cycles spent in ISSUE with the issue condition false.
  - burst_count [15:0]: counts rd_valid pulses.
- Both counters clear on areset and on request acceptance in IDLE, and saturate at all-ones.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mdma_pkg holds:
  - AXI_MAX_BURST=16, BEAT_BYTES=8, PAGE_BEATS=512.
  - The state enum.
- One natural sub-module: mdma_burst_len_calc, the combinational min(16, remaining, page beats left) used in CALC.

Test Plan:
- req_addr=0x1000, req_beats=40, fifo_count=0, engine model returns rlast after 4 cycles:
  - bursts (0x1000,16), (0x1080,16), (0x1100,8).
  - Exactly 3 rd_valid pulses, then one done pulse.
- req_addr=0x1FC0, req_beats=20:
  - bursts (0x1FC0,8), (0x2000,12); no burst crosses 0x2000.
- req_beats=0 → no rd_valid; done 2 cycles after acceptance; req_ready returns to 1.
- FIFO_DEPTH=256, fifo_count=245, req_beats=16:
  - ISSUE stalls with rd_valid=0.
  - Drop fifo_count to 240 → rd_valid next cycle with rd_burst_len=16.
- rd_free held low for 20 cycles after launch → no second rd_valid until rd_free=1. A req_valid during this time is not accepted.
- areset pulsed while in WAIT_FREE → next cycle: busy=0, req_ready=1, rd_valid=0; no done pulse.
